// File: rtl/fixed_point_pkg.sv
// Shared definitions for the IIR datapath fixed-point arithmetic blocks.
// The operand format is sign + 15-bit integer + 16-bit fraction.
package fixed_point_pkg;

    localparam int INT_W     = 15;
    localparam int FRAC_W    = 16;
    localparam int WORD_W    = 32;
    localparam int MAG_W     = INT_W + FRAC_W;
    localparam int DIV_STEPS = MAG_W + FRAC_W;
    localparam logic [MAG_W-1:0] SAT_MAG = 31'h7FFFFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } div_state_t;

    typedef struct packed {
        logic              sign;
        logic [INT_W-1:0]  int_mag;
        logic [FRAC_W-1:0] frac;
    } fxp_t;

endpackage

// File: rtl/fixed_point_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract.
module div_step
    import fixed_point_pkg::*;
#(
    parameter int STEP_MAG_W = MAG_W
) (
    input  logic [STEP_MAG_W:0]   i_rem,
    input  logic [STEP_MAG_W-1:0] i_divisor,
    input  logic                  i_bit,
    output logic [STEP_MAG_W:0]   o_rem,
    output logic                  o_qbit
);

    logic [STEP_MAG_W:0] w_shifted;
    logic [STEP_MAG_W:0] w_divisor_ext;

    assign w_shifted     = {i_rem[STEP_MAG_W-1:0], i_bit};
    assign w_divisor_ext = {1'b0, i_divisor};
    assign o_qbit        = (w_shifted >= w_divisor_ext);
    assign o_rem         = o_qbit ? (w_shifted - w_divisor_ext) : w_shifted;

endmodule

// File: rtl/fixed_point_divider.sv
// Iterative sign-magnitude fixed-point divider, one quotient bit per cycle.
// Result magnitude is floor((Na<<FRAC_W)/Nc), saturated on overflow or divide-by-zero.
module fixed_point_divider #(
    parameter int INT_W  = 15,
    parameter int FRAC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [INT_W-1:0]        A,
    input  logic [FRAC_W-1:0]       B,
    input  logic                    signA,
    input  logic [INT_W-1:0]        C,
    input  logic [FRAC_W-1:0]       D,
    input  logic                    signC,
    output logic                    ready,
    output logic                    done,
    output logic [INT_W+FRAC_W:0]   out,
    output logic                    overflow,
    output logic                    div_by_zero
);

    import fixed_point_pkg::div_state_t;
    import fixed_point_pkg::IDLE;
    import fixed_point_pkg::DIVIDE;
    import fixed_point_pkg::DONE;

    localparam int MAG_W  = INT_W + FRAC_W;
    localparam int REM_W  = MAG_W + 1;
    localparam int DIVD_W = MAG_W + FRAC_W;
    localparam int ITER_W = $clog2(DIVD_W);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DIVD_W - 1);

    div_state_t          r_state;
    logic [DIVD_W-1:0]   r_dividend;
    logic [REM_W-1:0]    r_rem;
    logic [MAG_W-1:0]    r_quot;
    logic [MAG_W-1:0]    r_divisor;
    logic [ITER_W-1:0]   r_iter;
    logic                r_sign;
    logic                r_ovf;
    logic                r_dbz;
    logic [MAG_W:0]      r_out;
    logic                r_overflow;
    logic                r_div_by_zero;
    logic                r_done;

    logic [MAG_W-1:0]    w_na;
    logic [MAG_W-1:0]    w_nc;
    logic [REM_W-1:0]    w_rem_next;
    logic                w_qbit;
    logic                w_sat;
    logic [MAG_W-1:0]    w_mag;
    logic                w_out_sign;

    assign w_na = {A, B};
    assign w_nc = {C, D};

    div_step #(
        .STEP_MAG_W (MAG_W)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_divisor (r_divisor),
        .i_bit     (r_dividend[DIVD_W-1]),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    // A zero magnitude never carries a negative sign.
    assign w_sat      = r_dbz | r_ovf;
    assign w_mag      = w_sat ? {MAG_W{1'b1}} : r_quot;
    assign w_out_sign = r_sign & (w_mag != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_dividend    <= '0;
            r_rem         <= '0;
            r_quot        <= '0;
            r_divisor     <= '0;
            r_iter        <= '0;
            r_sign        <= 1'b0;
            r_ovf         <= 1'b0;
            r_dbz         <= 1'b0;
            r_out         <= '0;
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign     <= signA ^ signC;
                        r_divisor  <= w_nc;
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_ovf      <= 1'b0;
                        r_iter     <= '0;
                        r_dividend <= {w_na, {FRAC_W{1'b0}}};
                        if (w_nc == '0) begin
                            r_dbz   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    // Any set bit leaving the top of the quotient means it needs more than MAG_W bits.
                    r_rem      <= w_rem_next;
                    r_quot     <= {r_quot[MAG_W-2:0], w_qbit};
                    r_ovf      <= r_ovf | r_quot[MAG_W-1];
                    r_dividend <= {r_dividend[DIVD_W-2:0], 1'b0};
                    r_iter     <= r_iter + ITER_W'(1);
                    if (r_iter == LAST_ITER) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_out         <= {w_out_sign, w_mag};
                    r_overflow    <= r_ovf & ~r_dbz;
                    r_div_by_zero <= r_dbz;
                    r_done        <= 1'b1;
                    r_state       <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready       = (r_state == IDLE);
    assign done        = r_done;
    assign out         = r_out;
    assign overflow    = r_overflow;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider: hand-computed quotients, flags, latency,
// back-to-back starts, ignored starts while busy, and mid-operation reset.
module tb_fixed_point_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] A;
    logic [15:0] B;
    logic        signA;
    logic [14:0] C;
    logic [15:0] D;
    logic        signC;
    logic        ready;
    logic        done;
    logic [31:0] out;
    logic        overflow;
    logic        div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fixed_point_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .signA       (signA),
        .C           (C),
        .D           (D),
        .signC       (signC),
        .ready       (ready),
        .done        (done),
        .out         (out),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [14:0] a, input logic [15:0] b, input logic sa,
                          input logic [14:0] c, input logic [15:0] d, input logic sc,
                          output int lat);
        A = a; B = b; signA = sa;
        C = c; D = d; signC = sc;
        start = 1'b1;
        tick;
        start = 1'b0;
        A = '0; B = '0; C = '0; D = '0; signA = 1'b0; signC = 1'b0;
        check("ready_busy", {31'b0, ready}, 32'd0);
        lat = 1;
        while (!done && lat < 200) begin
            tick;
            lat++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    initial begin
        int lat;
        int cyc;
        int dones;

        rst = 1'b1; start = 1'b0;
        A = '0; B = '0; C = '0; D = '0; signA = 1'b0; signC = 1'b0;
        tick;
        tick;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_out", out, 32'h0);
        check("rst_flags", {30'b0, overflow, div_by_zero}, 32'd0);
        rst = 1'b0;
        tick;

        // 3.0 / 1.5 = 2.0
        run_op(15'd3, 16'h0000, 1'b0, 15'd1, 16'h8000, 1'b0, lat);
        check("q3_out", out, 32'h00020000);
        check("q3_flags", {30'b0, overflow, div_by_zero}, 32'd0);
        check("q3_latency", lat, 32'd49);

        // back-to-back: -1.0 / 4.0 = -0.25
        run_op(15'd1, 16'h0000, 1'b1, 15'd4, 16'h0000, 1'b0, lat);
        check("neg_out", out, 32'h80004000);
        check("neg_latency", lat, 32'd49);

        // 1.0 / 3.0 truncates
        run_op(15'd1, 16'h0000, 1'b0, 15'd3, 16'h0000, 1'b0, lat);
        check("third_out", out, 32'h00005555);

        // -1.0 / 3.0 truncates toward zero
        run_op(15'd1, 16'h0000, 1'b1, 15'd3, 16'h0000, 1'b0, lat);
        check("negthird_out", out, 32'h80005555);

        // -3.0 / -1.5 = +2.0
        run_op(15'd3, 16'h0000, 1'b1, 15'd1, 16'h8000, 1'b1, lat);
        check("negneg_out", out, 32'h00020000);

        // divide by zero, negative dividend
        run_op(15'd5, 16'h0000, 1'b1, 15'd0, 16'h0000, 1'b0, lat);
        check("dbz_out", out, 32'hFFFFFFFF);
        check("dbz_flag", {31'b0, div_by_zero}, 32'd1);
        check("dbz_ovf", {31'b0, overflow}, 32'd0);
        check("dbz_latency", lat, 32'd2);

        // 16384.0 / 0.25 = 65536.0 overflows
        run_op(15'd16384, 16'h0000, 1'b0, 15'd0, 16'h4000, 1'b0, lat);
        check("ovf_out", out, 32'h7FFFFFFF);
        check("ovf_flag", {31'b0, overflow}, 32'd1);
        check("ovf_dbz", {31'b0, div_by_zero}, 32'd0);

        // 2.0 / 1.0 clears overflow
        run_op(15'd2, 16'h0000, 1'b0, 15'd1, 16'h0000, 1'b0, lat);
        check("after_ovf_out", out, 32'h00020000);
        check("after_ovf_flags", {30'b0, overflow, div_by_zero}, 32'd0);

        // reset at cycle 20 of a divide
        A = 15'd9; B = '0; signA = 1'b1; C = 15'd2; D = '0; signC = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (19) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_ready", {31'b0, ready}, 32'd1);
        check("midrst_out", out, 32'h0);
        check("midrst_done", {31'b0, done}, 32'd0);
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            tick;
            if (done) dones++;
        end
        check("midrst_no_done", dones, 32'd0);

        // 7.0 / 2.0 = 3.5 after reset
        run_op(15'd7, 16'h0000, 1'b0, 15'd2, 16'h0000, 1'b0, lat);
        check("postrst_out", out, 32'h00038000);
        check("postrst_latency", lat, 32'd49);

        // 0 / -7.0 with an ignored start while busy
        A = 15'd0; B = '0; signA = 1'b0; C = 15'd7; D = '0; signC = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1; dones = 0; lat = 0;
        while (cyc < 120) begin
            if (cyc == 10) begin
                start = 1'b1;
                A = 15'd1; C = 15'd1; signC = 1'b0;
            end else begin
                start = 1'b0;
            end
            tick;
            cyc++;
            if (done) begin
                dones++;
                if (lat == 0) lat = cyc;
            end
        end
        start = 1'b0;
        check("zero_out", out, 32'h00000000);
        check("zero_done_count", dones, 32'd1);
        check("zero_latency", lat, 32'd49);
        check("zero_flags", {30'b0, overflow, div_by_zero}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
